// File: rtl/nt_subckt_pkg.sv
// Shared types and the per-lane combine function for the Nt-node lane pipeline.
package nt_subckt_pkg;

  typedef enum logic [1:0] {
    NT_NOR  = 2'b00,
    NT_OR   = 2'b01,
    NT_XNOR = 2'b10,
    NT_ANDN = 2'b11
  } nt_mode_e;

  // Single-lane combine; callers replicate it across lanes, so it stays width-agnostic.
  function automatic logic nt_combine(nt_mode_e mode, logic d, logic sel);
    logic r;
    case (mode)
      NT_OR:   r = d | sel;
      NT_XNOR: r = ~(d ^ sel);
      NT_ANDN: r = d & ~sel;
      default: r = ~(d | sel);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nt_subckt_if.sv
// Beat/result bundle between stimulus registers, the lane pipe and the observer.
interface nt_subckt_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  import nt_subckt_pkg::*;

  logic             hold;
  logic             in_valid;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] sel_in;
  nt_mode_e         mode_in;
  logic             clr_count;
  logic             out_valid;
  logic [WIDTH-1:0] q_out;
  logic [CNT_W-1:0] hit_count;
  logic             hit_sat;

  modport master (
    output hold, in_valid, d_in, sel_in, mode_in, clr_count,
    input  out_valid, q_out, hit_count, hit_sat
  );

  modport slave (
    input  hold, in_valid, d_in, sel_in, mode_in, clr_count,
    output out_valid, q_out, hit_count, hit_sat
  );
endinterface

// File: rtl/nt_sat_counter.sv
// Saturating up-counter with clear priority; clear ignores the enable.
module nt_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (rst || clr)            count <= '0;
    else if (en && inc && !sat) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/nt_subckt_lane_pipe.sv
// WIDTH-lane Nt-node pipe: LAT-1 carry stages plus an output register, global hold, hit profiling.
module nt_subckt_lane_pipe
  import nt_subckt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int CNT_W = 8
) (
  input  logic          I1470_clk,
  input  logic          I1477_rst,
  nt_subckt_if.slave    bus
);

  localparam int STG = LAT - 1;

  // vld_pipe[STG] is the output valid; lower indices are the carry stages.
  logic [STG:0]                  vld_pipe;
  logic [STG-1:0][WIDTH-1:0]     d_pipe, sel_pipe;
  logic [STG-1:0][1:0]           mode_pipe;
  logic [STG-1:0][WIDTH-1:0]     d_src, sel_src;
  logic [STG-1:0][1:0]           mode_src;
  logic [STG-1:0]                v_src;
  logic [WIDTH-1:0]              comb, q_reg;
  logic                          hit;

  always_comb begin
    v_src       = '0;
    d_src       = '0;
    sel_src     = '0;
    mode_src    = '0;
    v_src[0]    = bus.in_valid;
    d_src[0]    = bus.d_in;
    sel_src[0]  = bus.sel_in;
    mode_src[0] = bus.mode_in;
    for (int k = 1; k < STG; k++) begin
      v_src[k]    = vld_pipe[k-1];
      d_src[k]    = d_pipe[k-1];
      sel_src[k]  = sel_pipe[k-1];
      mode_src[k] = mode_pipe[k-1];
    end
  end

  // Payload only loads behind a valid, so bubbles leave the last beat's data parked.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      vld_pipe  <= '0;
      d_pipe    <= '0;
      sel_pipe  <= '0;
      mode_pipe <= '0;
      q_reg     <= '0;
    end else if (!bus.hold) begin
      vld_pipe <= {vld_pipe[STG-1:0], bus.in_valid};
      for (int k = 0; k < STG; k++) begin
        if (v_src[k]) begin
          d_pipe[k]    <= d_src[k];
          sel_pipe[k]  <= sel_src[k];
          mode_pipe[k] <= mode_src[k];
        end
      end
      if (vld_pipe[STG-1]) q_reg <= comb;
    end
  end

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    assign comb[l] = nt_combine(nt_mode_e'(mode_pipe[STG-1]),
                                d_pipe[STG-1][l], sel_pipe[STG-1][l]);
  end

  assign hit = vld_pipe[STG-1] & (|comb);

  nt_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (I1470_clk),
    .rst   (I1477_rst),
    .en    (~bus.hold),
    .inc   (hit),
    .clr   (bus.clr_count),
    .count (bus.hit_count),
    .sat   (bus.hit_sat)
  );

  assign bus.out_valid = vld_pipe[STG];
  assign bus.q_out     = q_reg;

endmodule
